// File: rtl/dec_srat_ckpt_pkg.sv
// Shared constants for the speculative register alias table (SRAT) and its
// checkpoint bookkeeping, plus the identity map used at reset.
// Optional feature macro used by dec_srat_ckpt: DEC_SRAT_INGROUP_BYPASS_EN.
package dec_srat_ckpt_pkg;
   localparam int ARF_NUM  = 32;
   localparam int ARF_W    = 5;
   localparam int PRF_W    = 7;
   localparam int RN_W     = 4;
   localparam int CKPT_NUM = 4;
   localparam int CKPT_W   = 2;
   localparam int SLOT_W   = $clog2(RN_W);

   // Reset mapping: ARF i maps to PRF i (zero-extended).
   function automatic logic [PRF_W-1:0] ident_prf(input int i);
      return PRF_W'(i);
   endfunction
endpackage

// File: rtl/dec_srat_ckpt_age.sv
// Checkpoint id manager for the SRAT.
// Tracks which checkpoint ids are live, their relative age, hands out the
// lowest free id and kills a recovered id together with everything younger.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   alloc                   request a new checkpoint this cycle
//   rel, rel_id             branch resolved correctly; free rel_id
//   recover, recover_id     mispredict; kill recover_id and all younger ids
//   flush                   exception flush; kill every checkpoint
//   rdy                     a free id exists and no recover/flush this cycle
//   alloc_id                lowest free id (combinational)
//   alloc_fire              alloc accepted this cycle
module dec_srat_ckpt_age
   import dec_srat_ckpt_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alloc,
   input  logic              rel,
   input  logic [CKPT_W-1:0] rel_id,
   input  logic              recover,
   input  logic [CKPT_W-1:0] recover_id,
   input  logic              flush,
   output logic              rdy,
   output logic [CKPT_W-1:0] alloc_id,
   output logic              alloc_fire
);

   logic [CKPT_NUM-1:0] valid_q;
   // older_q[i][j] set: checkpoint j was live when i was allocated (j older than i)
   logic [CKPT_NUM-1:0] older_q [CKPT_NUM];
   logic [CKPT_NUM-1:0] older_d [CKPT_NUM];
   logic [CKPT_NUM-1:0] kill;
   logic [CKPT_NUM-1:0] rel_mask;
   logic [CKPT_NUM-1:0] alloc_mask;

   always_comb begin
      alloc_id = '0;
      for (int i = CKPT_NUM-1; i >= 0; i--) begin
         if (!valid_q[i]) alloc_id = CKPT_W'(i);
      end
      rdy        = ~(&valid_q) & ~recover & ~flush;
      alloc_fire = alloc & rdy;
      for (int i = 0; i < CKPT_NUM; i++) begin
         kill[i]       = recover & ((CKPT_W'(i) == recover_id) | older_q[i][recover_id]);
         rel_mask[i]   = rel & (CKPT_W'(i) == rel_id);
         alloc_mask[i] = alloc_fire & (CKPT_W'(i) == alloc_id);
      end
   end

   // The new id is younger than every live id; clearing its column removes
   // stale ordering left over from its previous lifetime.
   always_comb begin
      older_d = older_q;
      if (alloc_fire) begin
         for (int i = 0; i < CKPT_NUM; i++) older_d[i][alloc_id] = 1'b0;
         older_d[alloc_id] = valid_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         for (int i = 0; i < CKPT_NUM; i++) older_q[i] <= '0;
      end else if (flush) begin
         valid_q <= '0;
      end else begin
         valid_q <= (valid_q & ~kill & ~rel_mask) | alloc_mask;
         older_q <= older_d;
      end
   end
endmodule

// File: rtl/dec_srat_ckpt.sv
// Speculative register alias table for decode/rename with branch checkpoints.
// Maps ARF codes to PRF codes for RN_W rename slots per cycle (3 sources and
// the old-destination lookup per slot), snapshots the table on branch rename,
// restores a snapshot in one cycle on mispredict and reloads the committed
// map on exception flush.
// Optional feature: `define DEC_SRAT_INGROUP_BYPASS_EN forwards in-group
// writes of lower slots to the lookups of higher slots.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   i_src_arf / o_src_prf           3 source lookups per slot
//   i_wren, i_wr_dst, i_wr_prf      destination renames per slot
//   o_wr_pprf                       previous mapping of i_wr_dst (to ROB)
//   i_ckpt_alloc, i_ckpt_slot       snapshot request, covering slots 0..i_ckpt_slot
//   o_ckpt_rdy, o_ckpt_id           checkpoint availability / granted id
//   i_ckpt_rel, i_ckpt_rel_id       free a checkpoint
//   i_recover, i_recover_id         mispredict restore
//   i_except_flush, i_flush_prf     reload from the committed map
module dec_srat_ckpt
   import dec_srat_ckpt_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [RN_W*3*ARF_W-1:0]    i_src_arf,
   output logic [RN_W*3*PRF_W-1:0]    o_src_prf,
   input  logic [RN_W-1:0]            i_wren,
   input  logic [RN_W*ARF_W-1:0]      i_wr_dst,
   input  logic [RN_W*PRF_W-1:0]      i_wr_prf,
   output logic [RN_W*PRF_W-1:0]      o_wr_pprf,
   input  logic                       i_ckpt_alloc,
   input  logic [SLOT_W-1:0]          i_ckpt_slot,
   output logic                       o_ckpt_rdy,
   output logic [CKPT_W-1:0]          o_ckpt_id,
   input  logic                       i_ckpt_rel,
   input  logic [CKPT_W-1:0]          i_ckpt_rel_id,
   input  logic                       i_recover,
   input  logic [CKPT_W-1:0]          i_recover_id,
   input  logic                       i_except_flush,
   input  logic [ARF_NUM*PRF_W-1:0]   i_flush_prf
);

   logic [PRF_W-1:0] map_q  [ARF_NUM];
   logic [PRF_W-1:0] map_d  [ARF_NUM];
   logic [PRF_W-1:0] snap_d [ARF_NUM];
   logic [PRF_W-1:0] ckpt_q [CKPT_NUM][ARF_NUM];
   logic             alloc_fire;
   logic [ARF_W-1:0] rd_arf;
   logic [PRF_W-1:0] rd_val;

`ifdef DEC_SRAT_INGROUP_BYPASS_EN
   // Youngest lower slot writing the same ARF supplies the value.
   function automatic logic [PRF_W-1:0] fwd(input logic [PRF_W-1:0]       base,
                                            input logic [ARF_W-1:0]       arf,
                                            input int                     k,
                                            input logic [RN_W-1:0]        wren,
                                            input logic [RN_W*ARF_W-1:0]  dst,
                                            input logic [RN_W*PRF_W-1:0]  prf);
      logic [PRF_W-1:0] v;
      v = base;
      for (int j = 0; j < RN_W; j++) begin
         if (j < k && wren[j] && dst[j*ARF_W +: ARF_W] == arf) v = prf[j*PRF_W +: PRF_W];
      end
      return v;
   endfunction
`endif

   dec_srat_ckpt_age u_age (
      .clk        (clk),
      .rst_n      (rst_n),
      .alloc      (i_ckpt_alloc),
      .rel        (i_ckpt_rel),
      .rel_id     (i_ckpt_rel_id),
      .recover    (i_recover),
      .recover_id (i_recover_id),
      .flush      (i_except_flush),
      .rdy        (o_ckpt_rdy),
      .alloc_id   (o_ckpt_id),
      .alloc_fire (alloc_fire)
   );

   // Combinational lookups: 3 sources per slot, then the old-destination read.
   always_comb begin
      o_src_prf = '0;
      o_wr_pprf = '0;
      rd_arf    = '0;
      rd_val    = '0;
      for (int k = 0; k < RN_W; k++) begin
         for (int s = 0; s < 3; s++) begin
            rd_arf = i_src_arf[(k*3+s)*ARF_W +: ARF_W];
            rd_val = map_q[rd_arf];
`ifdef DEC_SRAT_INGROUP_BYPASS_EN
            rd_val = fwd(rd_val, rd_arf, k, i_wren, i_wr_dst, i_wr_prf);
`endif
            if (rd_arf == '0) rd_val = '0;
            o_src_prf[(k*3+s)*PRF_W +: PRF_W] = rd_val;
         end
         rd_arf = i_wr_dst[k*ARF_W +: ARF_W];
         rd_val = map_q[rd_arf];
`ifdef DEC_SRAT_INGROUP_BYPASS_EN
         rd_val = fwd(rd_val, rd_arf, k, i_wren, i_wr_dst, i_wr_prf);
`endif
         if (rd_arf == '0) rd_val = '0;
         o_wr_pprf[k*PRF_W +: PRF_W] = rd_val;
      end
   end

   // Ascending slot order makes the highest slot win on duplicate dests.
   // The snapshot sees only the slots up to and including the branch.
   always_comb begin
      map_d  = map_q;
      snap_d = map_q;
      for (int k = 0; k < RN_W; k++) begin
         if (i_wren[k] && i_wr_dst[k*ARF_W +: ARF_W] != '0) begin
            map_d[i_wr_dst[k*ARF_W +: ARF_W]] = i_wr_prf[k*PRF_W +: PRF_W];
            if (SLOT_W'(k) <= i_ckpt_slot)
               snap_d[i_wr_dst[k*ARF_W +: ARF_W]] = i_wr_prf[k*PRF_W +: PRF_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ARF_NUM; i++) map_q[i] <= ident_prf(i);
      end else if (i_except_flush) begin
         for (int i = 0; i < ARF_NUM; i++)
            map_q[i] <= (i == 0) ? '0 : i_flush_prf[i*PRF_W +: PRF_W];
      end else if (i_recover) begin
         map_q <= ckpt_q[i_recover_id];
      end else begin
         map_q <= map_d;
      end
   end

   // Snapshot storage is only meaningful while its id is valid, so no reset.
   always_ff @(posedge clk) begin
      if (alloc_fire) ckpt_q[o_ckpt_id] <= snap_d;
   end
endmodule

// File: tb/tb_dec_srat_ckpt.sv
module tb_dec_srat_ckpt;
   import dec_srat_ckpt_pkg::*;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic [RN_W*3*ARF_W-1:0]  i_src_arf;
   logic [RN_W*3*PRF_W-1:0]  o_src_prf;
   logic [RN_W-1:0]          i_wren;
   logic [RN_W*ARF_W-1:0]    i_wr_dst;
   logic [RN_W*PRF_W-1:0]    i_wr_prf;
   logic [RN_W*PRF_W-1:0]    o_wr_pprf;
   logic                     i_ckpt_alloc;
   logic [SLOT_W-1:0]        i_ckpt_slot;
   logic                     o_ckpt_rdy;
   logic [CKPT_W-1:0]        o_ckpt_id;
   logic                     i_ckpt_rel;
   logic [CKPT_W-1:0]        i_ckpt_rel_id;
   logic                     i_recover;
   logic [CKPT_W-1:0]        i_recover_id;
   logic                     i_except_flush;
   logic [ARF_NUM*PRF_W-1:0] i_flush_prf;

   dec_srat_ckpt dut (
      .clk(clk), .rst_n(rst_n),
      .i_src_arf(i_src_arf), .o_src_prf(o_src_prf),
      .i_wren(i_wren), .i_wr_dst(i_wr_dst), .i_wr_prf(i_wr_prf), .o_wr_pprf(o_wr_pprf),
      .i_ckpt_alloc(i_ckpt_alloc), .i_ckpt_slot(i_ckpt_slot),
      .o_ckpt_rdy(o_ckpt_rdy), .o_ckpt_id(o_ckpt_id),
      .i_ckpt_rel(i_ckpt_rel), .i_ckpt_rel_id(i_ckpt_rel_id),
      .i_recover(i_recover), .i_recover_id(i_recover_id),
      .i_except_flush(i_except_flush), .i_flush_prf(i_flush_prf)
   );

   always #5 clk = ~clk;

   localparam int SEL_SRC = 0, SEL_PPRF = 1, SEL_RDY = 2, SEL_ID = 3;

`ifdef DEC_SRAT_INGROUP_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct {
      string name;
      int    sel;
      int    idx;
      int    exp;
   } chk_t;

   chk_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic int get_out(input int sel, input int idx);
      case (sel)
         SEL_SRC:  return int'(o_src_prf[idx*PRF_W +: PRF_W]);
         SEL_PPRF: return int'(o_wr_pprf[idx*PRF_W +: PRF_W]);
         SEL_RDY:  return int'(o_ckpt_rdy);
         default:  return int'(o_ckpt_id);
      endcase
   endfunction

   // Monitor: every expectation queued for this cycle is checked mid-cycle.
   always @(negedge clk) begin
      chk_t c;
      int   act;
      while (q.size() > 0) begin
         c   = q.pop_front();
         act = get_out(c.sel, c.idx);
         n_tests++;
         if (act != c.exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", c.name, act, c.exp);
         end
      end
   end

   task automatic expect_out(input string nm, input int sel, input int idx, input int e);
      chk_t c;
      c.name = nm; c.sel = sel; c.idx = idx; c.exp = e;
      q.push_back(c);
   endtask

   task automatic idle();
      i_src_arf      = '0;
      i_wren         = '0;
      i_wr_dst       = '0;
      i_wr_prf       = '0;
      i_ckpt_alloc   = 1'b0;
      i_ckpt_slot    = '0;
      i_ckpt_rel     = 1'b0;
      i_ckpt_rel_id  = '0;
      i_recover      = 1'b0;
      i_recover_id   = '0;
      i_except_flush = 1'b0;
   endtask

   task automatic src(input int k, input int s, input int arf, input int e, input string nm);
      i_src_arf[(k*3+s)*ARF_W +: ARF_W] = ARF_W'(arf);
      expect_out(nm, SEL_SRC, k*3+s, e);
   endtask

   task automatic wr(input int k, input int dst, input int prf);
      i_wren[k]                   = 1'b1;
      i_wr_dst[k*ARF_W +: ARF_W]  = ARF_W'(dst);
      i_wr_prf[k*PRF_W +: PRF_W]  = PRF_W'(prf);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      idle();
   endtask

   initial begin
      rst_n = 1'b0;
      i_flush_prf = '0;
      idle();
      @(posedge clk);
      #1;

      // 1. reset state, single write, readback and old-dest
      src(0, 0, 5, 5, "rst_src5");
      src(1, 2, 31, 31, "rst_src31");
      expect_out("rst_rdy", SEL_RDY, 0, 1);
      expect_out("rst_id", SEL_ID, 0, 0);
      step();
      rst_n = 1'b1;
      wr(0, 5, 40);
      wr(1, 0, 99);
      src(0, 0, 5, 5, "pre_wr_src5");
      expect_out("pre_wr_pprf5", SEL_PPRF, 0, 5);
      step();
      src(0, 0, 5, 40, "post_wr_src5");
      src(0, 1, 0, 0, "arf0_read");
      i_wr_dst[0 +: ARF_W] = ARF_W'(5);
      expect_out("post_wr_pprf5", SEL_PPRF, 0, 40);
      step();

      // 2. duplicate dest in one group
      wr(1, 7, 50);
      wr(3, 7, 51);
      src(2, 0, 7, BYP ? 50 : 7, "grp_src7_slot2");
      expect_out("grp_pprf7_slot3", SEL_PPRF, 3, BYP ? 50 : 7);
      expect_out("grp_pprf7_slot1", SEL_PPRF, 1, 7);
      step();
      src(0, 0, 7, 51, "dup_highest_wins");
      step();

      // 3. partial snapshot and recover
      i_ckpt_alloc = 1'b1;
      i_ckpt_slot  = SLOT_W'(1);
      wr(0, 3, 60);
      wr(2, 4, 61);
      expect_out("ck_alloc_id0", SEL_ID, 0, 0);
      expect_out("ck_alloc_rdy", SEL_RDY, 0, 1);
      step();
      wr(0, 3, 70);
      wr(1, 4, 71);
      src(0, 0, 3, 60, "ck_arf3_60");
      src(0, 1, 4, 61, "ck_arf4_61");
      expect_out("ck_next_id1", SEL_ID, 0, 1);
      step();
      i_recover    = 1'b1;
      i_recover_id = '0;
      wr(0, 3, 99);
      src(0, 0, 3, 70, "ck_arf3_70");
      src(0, 1, 4, 71, "ck_arf4_71");
      expect_out("rec_rdy_low", SEL_RDY, 0, 0);
      step();
      src(0, 0, 3, 60, "rec_arf3");
      src(0, 1, 4, 4, "rec_arf4");
      expect_out("rec_id_freed", SEL_ID, 0, 0);
      expect_out("rec_rdy_back", SEL_RDY, 0, 1);
      step();

      // 4. fill all checkpoints, then recover the second
      for (int k = 0; k < CKPT_NUM; k++) begin
         i_ckpt_alloc = 1'b1;
         expect_out($sformatf("fill_id%0d", k), SEL_ID, 0, k);
         expect_out($sformatf("fill_rdy%0d", k), SEL_RDY, 0, 1);
         step();
      end
      i_ckpt_alloc = 1'b1;
      expect_out("full_rdy", SEL_RDY, 0, 0);
      step();
      i_recover    = 1'b1;
      i_recover_id = CKPT_W'(1);
      expect_out("full_still_rdy0", SEL_RDY, 0, 0);
      step();
      i_ckpt_alloc = 1'b1;
      expect_out("kill_rdy", SEL_RDY, 0, 1);
      expect_out("kill_id1", SEL_ID, 0, 1);
      step();
      i_ckpt_rel    = 1'b1;
      i_ckpt_rel_id = '0;
      expect_out("after_alloc_id2", SEL_ID, 0, 2);
      step();
      expect_out("rel_id0", SEL_ID, 0, 0);
      step();

      // 5. flush beats recover and writes
      for (int i = 0; i < ARF_NUM; i++) i_flush_prf[i*PRF_W +: PRF_W] = PRF_W'(i + 32);
      i_except_flush = 1'b1;
      i_recover      = 1'b1;
      i_recover_id   = CKPT_W'(1);
      wr(0, 9, 5);
      expect_out("flush_rdy_low", SEL_RDY, 0, 0);
      step();
      src(0, 0, 0, 0, "fl_arf0");
      src(0, 1, 1, 33, "fl_arf1");
      src(0, 2, 9, 41, "fl_arf9");
      src(1, 0, 31, 63, "fl_arf31");
      src(1, 1, 5, 37, "fl_arf5");
      expect_out("fl_id0", SEL_ID, 0, 0);
      expect_out("fl_rdy", SEL_RDY, 0, 1);
      i_ckpt_alloc = 1'b1;
      step();
      expect_out("fl_next_id1", SEL_ID, 0, 1);
      i_ckpt_alloc = 1'b1;
      wr(0, 5, 77);
      step();

      // 6. async reset with live checkpoints
      src(0, 0, 5, 77, "pre_rst_arf5");
      expect_out("pre_rst_id2", SEL_ID, 0, 2);
      step();
      rst_n = 1'b0;
      src(0, 0, 5, 5, "arst_arf5");
      src(0, 1, 9, 9, "arst_arf9");
      expect_out("arst_rdy", SEL_RDY, 0, 1);
      expect_out("arst_id", SEL_ID, 0, 0);
      step();
      rst_n = 1'b1;
      src(0, 0, 1, 1, "post_rst_arf1");
      expect_out("post_rst_id", SEL_ID, 0, 0);
      step();

      @(negedge clk);
      #1;
      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL queue_drain: got %0d pending, expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
